// File: rtl/tty_pkg.sv
// ---------------------------------------------------------------------------
// tty_pkg
// Shared definitions for the console teletype IOT device.
//   ser_state_e : serial FSM encoding used by both receiver and transmitter
//   SKIP/CLR/XFER : IR micro-op bit positions
//   KBD/TPR : device codes served by this block (keyboard 03, printer 04)
// ---------------------------------------------------------------------------
package tty_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_e;

    localparam int SKIP = 0;
    localparam int CLR  = 1;
    localparam int XFER = 2;

    localparam logic [2:0] KBD = 3'o3;
    localparam logic [2:0] TPR = 3'o4;

endpackage

// File: rtl/tty_uart_core.sv
// ---------------------------------------------------------------------------
// tty_uart_core
// 8N1 serial receiver and transmitter for the teletype device.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   rxd             : asynchronous serial input (idle high)
//   rx_valid        : one-cycle pulse, rx_data holds a good byte
//   rx_data[7:0]    : received byte (valid with rx_valid)
//   tx_start        : one-cycle request to send tx_data (ignored while busy)
//   tx_data[7:0]    : byte to send, sampled with tx_start
//   tx_busy         : transmitter frame in progress
//   tx_done         : one-cycle pulse on the final cycle of the stop bit
//   txd             : registered serial output (idle high)
// ---------------------------------------------------------------------------
module tty_uart_core
    import tty_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    // sync_q[0..1] synchronise rxd; sync_q[2] is the previous synchronised
    // value, used to find the falling edge of the start bit.
    logic [2:0]  sync_q, sync_d;
    logic        rxd_s;
    logic        rx_fall;

    ser_state_e  rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;

    ser_state_e  tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    assign rxd_s   = sync_q[1];
    assign rx_fall = sync_q[2] & ~sync_q[1];
    assign rx_data = rx_shift_q;
    assign tx_busy = (tx_state_q != IDLE);
    assign txd     = txd_q;

    // Receiver: start is qualified at mid-bit, data sampled a full bit later.
    always_comb begin
        sync_d     = {sync_q[1:0], rxd};
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = START;
            end
            START: begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // Line back high by mid-bit means a glitch, not a start.
                    rx_state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = STOP;
                end
            end
            STOP: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d   = '0;
                    // A low stop bit is a framing error: drop the byte.
                    rx_valid   = rxd_s;
                    rx_state_d = IDLE;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // Transmitter: txd is registered from the next state so it changes
    // exactly on the state transition edge.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_done    = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                if (tx_start) begin
                    tx_shift_d = tx_data;
                    tx_bit_d   = '0;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == 3'd7) tx_state_d = STOP;
                end
            end
            STOP: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_done    = 1'b1;
                    tx_state_d = IDLE;
                end
            end
            default: tx_state_d = IDLE;
        endcase

        case (tx_state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= 3'b111;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
        end
    end

    // Shift registers are pure data and are always loaded before use.
    always_ff @(posedge clk) begin
        rx_shift_q <= rx_shift_d;
        tx_shift_q <= tx_shift_d;
    end

endmodule

// File: rtl/tty_iot_device.sv
// ---------------------------------------------------------------------------
// tty_iot_device
// Console teletype: responder for keyboard (603x) and teleprinter (604x) IOTs.
// Ports:
//   clk, reset       : system clock, synchronous active-high reset
//   IOT603x/IOT604x  : device select levels held for the whole IOT
//   IR[2:0]          : IOT micro-op bits (SKIP=0, CLR=1, XFER=2)
//   DONE             : one-cycle end-of-IOT pulse; all state changes here
//   AC[7:0]          : printer data source (and KIE enable bit)
//   skip, clearAC    : combinational responses while a select is high
//   orAC[7:0]        : rbuf on keyboard XFER, else zero
//   irq              : only with TTY_IRQ_EN, ie & (kbd_flag | tpr_flag)
//   rxd / txd        : 8N1 serial keyboard input / printer output
// Build option: define TTY_IRQ_EN to add the interrupt enable (6035 = KIE).
// ---------------------------------------------------------------------------
module tty_iot_device
    import tty_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       IOT603x,
    input  logic       IOT604x,
    input  logic [2:0] IR,
    input  logic       DONE,
    input  logic [7:0] AC,
    output logic       skip,
    output logic       clearAC,
    output logic [7:0] orAC,
`ifdef TTY_IRQ_EN
    output logic       irq,
`endif
    input  logic       rxd,
    output logic       txd
);

    logic       kbd_flag_q, kbd_flag_d;
    logic       tpr_flag_q, tpr_flag_d;
    logic [7:0] rbuf_q, rbuf_d;
    logic [7:0] tbuf_q, tbuf_d;

    logic       kbd_done, tpr_done;
    logic       rx_valid, tx_busy, tx_done, tx_start;
    logic [7:0] rx_data;

    assign kbd_done = DONE & IOT603x;
    assign tpr_done = DONE & IOT604x;
    // A load while the printer is busy is dropped; the frame runs on.
    assign tx_start = tpr_done & IR[XFER] & ~tx_busy;

    tty_uart_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_start (tx_start),
        .tx_data  (tbuf_d),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .txd      (txd)
    );

    always_comb begin
        skip    = (IOT603x & IR[SKIP] & kbd_flag_q) | (IOT604x & IR[SKIP] & tpr_flag_q);
        clearAC = IOT603x & IR[CLR];
        orAC    = (IOT603x & IR[XFER]) ? rbuf_q : 8'h00;
    end

    // Flag updates: clears are applied first so a same-cycle set wins.
    always_comb begin
        kbd_flag_d = kbd_flag_q;
        if (kbd_done & IR[CLR]) kbd_flag_d = 1'b0;
        if (rx_valid)           kbd_flag_d = 1'b1;

        rbuf_d = rx_valid ? rx_data : rbuf_q;

        tpr_flag_d = tpr_flag_q;
        if (tpr_done & (IR == 3'b000)) tpr_flag_d = 1'b1;
        if (tpr_done & IR[CLR])        tpr_flag_d = 1'b0;
        if (tx_done)                   tpr_flag_d = 1'b1;

        tbuf_d = tx_start ? AC : tbuf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_flag_q <= 1'b0;
            tpr_flag_q <= 1'b0;
            rbuf_q     <= 8'h00;
            tbuf_q     <= 8'h00;
        end else begin
            kbd_flag_q <= kbd_flag_d;
            tpr_flag_q <= tpr_flag_d;
            rbuf_q     <= rbuf_d;
            tbuf_q     <= tbuf_d;
        end
    end

`ifdef TTY_IRQ_EN
    logic ie_q, ie_d;

    always_comb begin
        ie_d = ie_q;
        if (kbd_done & (IR == 3'b101)) ie_d = AC[0];
    end

    always_ff @(posedge clk) begin
        if (reset) ie_q <= 1'b1;
        else       ie_q <= ie_d;
    end

    assign irq = ie_q & (kbd_flag_q | tpr_flag_q);
`endif

endmodule

// File: doc/tty_iot_device.md
Name: tty_iot_device

Overview:
- Console teletype device, the responder side of the IOT instruction path.
- Consumes the device-03 (keyboard) and device-04 (teleprinter) select strobes produced by the IOT decoder, plus the DONE end-of-IOT pulse.
- Returns skip, clear-AC and OR-into-AC data to the CPU.
- Contains an 8N1 serial receiver (keyboard) and transmitter (teleprinter).

Parameters:
- CLKS_PER_BIT, 104, clk cycles per serial bit; minimum 4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- IOT603x  in  1  keyboard device select; level held for the whole IOT
- IOT604x  in  1  teleprinter device select; level held for the whole IOT
- IR  in  3  IR[2:0], IOT micro-op bits
- DONE  in  1  one-cycle end-of-IOT pulse; side effects commit here
- AC  in  8  AC[7:0], printer data source
- skip  out  1  skip request to CPU
- clearAC  out  1  CPU clears AC at DONE
- orAC  out  8  OR'ed into AC[7:0] at DONE; zero when not driving
- rxd  in  1  serial in, idle high, asynchronous
- txd  out  1  serial out, idle high

Behaviour:
- Clock/reset: single clock domain on clk. Reset is synchronous, active-high.
- Reset values: txd=1; kbd_flag=0; tpr_flag=0; rbuf=0; tbuf=0; both FSMs IDLE. Reset mid-frame aborts the frame; txd returns high on the next cycle.
- Combinational outputs, valid while the strobe is high (CPU samples before DONE):
  - skip = (IOT603x & IR[0] & kbd_flag) | (IOT604x & IR[0] & tpr_flag)
  - clearAC = IOT603x & IR[1]
  - orAC = (IOT603x & IR[2]) ? rbuf : 0
  - All outputs are 0 when neither strobe is high.
- Committed side effects occur only on the cycle with DONE=1. Each IOT executes exactly once.
  - Keyboard (603x): IR[1] clears kbd_flag. Yields KCF 6030, KSF 6031, KCC 6032, KRS 6034, KRB 6036.
  - Teleprinter (604x):
    - IR=000 sets tpr_flag (TFL).
    - IR[1] clears tpr_flag.
    - IR[2] loads tbuf<=AC and starts TX (TPC 6044, TLS 6046).
- Receiver:
  - rxd passes through a 2-flop synchroniser.
  - States: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: falling edge starts a count to half a bit.
  - START: if rxd is still low at mid-bit, go to DATA; otherwise it is a glitch, return to IDLE.
  - DATA: sample 8 bits LSB first, one every CLKS_PER_BIT.
  - STOP: stop bit 1 -> rbuf<=shift register and kbd_flag<=1. Stop bit 0 -> framing error; byte discarded, flag unchanged.
  - A new byte overwrites rbuf even if kbd_flag is still set (overrun is silent).
- Transmitter:
  - States: IDLE -> START -> DATA -> STOP -> IDLE, each bit held CLKS_PER_BIT cycles.
  - txd sequence: 0, d0..d7, 1.
  - tpr_flag<=1 on the final cycle of the stop bit.
  - A load while TX is busy is ignored: tbuf unchanged, frame continues. The TLS flag-clear still applies.
- Simultaneous events:
  - RX completion on the same cycle as a KCC/KRB clear: the set wins, kbd_flag=1.
  - TX completion on the same cycle as a TCF clear: the set wins.

Optional Feature:
- Macro: TTY_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) and internal register ie (reset 1).
  - 6035 (KIE) on DONE: ie<=AC[0].
  - irq = ie & (kbd_flag | tpr_flag).
- When undefined:
  - No irq port and no ie register.
  - 6035 behaves as KRS: 6035 = IR[0] & IR[2], i.e. skip and OR only.

Decomposition:
- Shared package tty_pkg:
  - Serial FSM state encoding enum (IDLE, START, DATA, STOP).
  - IOT micro-op bit index constants: SKIP=0, CLR=1, XFER=2.
  - Device codes KBD=3'o3, TPR=3'o4.
- One natural sub-module: tty_uart_core. It holds the RX/TX FSMs, baud counters and synchroniser, with ready/valid-style pulses to the IOT glue.

Test Plan:
- RX byte 0x5A on rxd at CLKS_PER_BIT=8 -> kbd_flag=1 at mid-stop-bit. Then KSF: skip=1. KRB with DONE: clearAC=1, orAC=0x5A, kbd_flag=0 next cycle.
- TLS with AC=0xC3 -> txd low for 8 clks, then bits 1,1,0,0,0,0,1,1, then high. tpr_flag=1 after 80 clks. TSF: skip=1.
- TPC issued while TX busy with 0x41 -> serial output remains 0x41; tbuf not changed to the new AC.
- RX with stop bit 0 -> kbd_flag stays 0 and rbuf unchanged.
- KCC DONE on the same cycle as RX completion of 0x33 -> kbd_flag=1, rbuf=0x33.
- reset asserted mid-TX frame -> next cycle txd=1, tpr_flag=0, TX FSM IDLE. With TTY_IRQ_EN: irq=0 until a flag sets, then irq=1 with ie=1.
